// File: rtl/decrypt_pipe_param.sv
// Parametrised valid/ready decryption pipeline: NUM_STAGES keyed rounds over 4-word beats,
// header bypass, loadable key bank and a saturating count of delivered decrypted beats.
module decrypt_pipe_param #(
  parameter int unsigned W          = 16,
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*W-1:0]          in_data,
  input  logic [7:0]              in_ctrl,
  input  logic                    in_wr,
  output logic                    in_rdy,
  input  logic [NUM_STAGES*W-1:0] key_in,
  input  logic                    key_wr,
  output logic                    key_rdy,
  output logic [4*W-1:0]          out_data,
  output logic [7:0]              out_ctrl,
  output logic                    out_wr,
  input  logic                    out_rdy,
  output logic [CNT_W-1:0]        dec_cnt
);

  localparam int unsigned N  = NUM_STAGES;
  localparam int unsigned BW = 4 * W;

  function automatic logic [BW-1:0] round_f(input logic [BW-1:0] d, input logic [W-1:0] k);
    logic [W-1:0] t0, t1, t2, t3;
    t0 = d[0 +: W] ^ k;
    t1 = d[W +: W] + k;
    t2 = d[2*W +: W] - k;
    t3 = d[3*W +: W] ^ {k[W-2:0], k[W-1]};
    return {t2, t3, t0, t1};
  endfunction

  logic [BW-1:0]  r_data [N];
  logic [7:0]     r_ctrl [N];
  logic [N-1:0]   r_v;
  logic [N*W-1:0] r_key;
  logic [CNT_W-1:0] r_cnt;

  logic [N-1:0]   w_adv;
  logic [N-1:0]   w_load;
  logic [BW-1:0]  w_rnd [N];
  logic [7:0]     w_cin [N];
  logic           w_in_acc;

  always_comb begin
    w_adv = '0;
    for (int i = 0; i < N; i++) begin
      // A stage moves if any later stage is empty (bubble collapses) or the tail drains.
      w_adv[i] = r_v[i] & (out_rdy | (|(~r_v >> (i + 1))));
    end
  end

  assign in_rdy   = ~r_v[0] | w_adv[0];
  assign w_in_acc = in_wr & in_rdy;

  always_comb begin
    w_load    = w_adv << 1;
    w_load[0] = w_in_acc;
  end

  for (genvar g = 0; g < N; g++) begin : g_stage
    logic [BW-1:0] w_din;
    if (g == 0) begin : g_head
      assign w_din    = in_data;
      assign w_cin[g] = in_ctrl;
    end else begin : g_body
      assign w_din    = r_data[g-1];
      assign w_cin[g] = r_ctrl[g-1];
    end
    assign w_rnd[g] = (w_cin[g] != 8'h00) ? w_din : round_f(w_din, r_key[W*g +: W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < N; i++) begin
        r_data[i] <= '0;
        r_ctrl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_load[i]) begin
          r_data[i] <= w_rnd[i];
          r_ctrl[i] <= w_cin[i];
          r_v[i]    <= 1'b1;
        end else if (w_adv[i]) begin
          r_v[i] <= 1'b0;
        end
      end
    end
  end

  // Keys only change with the pipe empty and nothing arriving, so no beat sees a mixed bank.
  assign key_rdy = ~(|r_v) & ~in_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
    end else if (key_wr && key_rdy) begin
      r_key <= key_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (out_wr && out_rdy && (out_ctrl == 8'h00) && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_wr   = r_v[N-1];
  assign out_data = r_data[N-1];
  assign out_ctrl = r_ctrl[N-1];
  assign dec_cnt  = r_cnt;

endmodule

// File: tb/tb_decrypt_pipe_param.sv
// Self-checking bench: 5-stage instance against a word-level reference model, plus a
// single-stage, 4-bit-counter instance for hand-computed round vectors and saturation.
module tb_decrypt_pipe_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 5-stage DUT
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        in_wr, in_rdy, key_wr, key_rdy, out_wr, out_rdy;
  logic [79:0] key_in;
  logic [31:0] dec_cnt;

  // 1-stage DUT with 4-bit counter
  logic [63:0] b_in_data, b_out_data;
  logic [7:0]  b_in_ctrl, b_out_ctrl;
  logic        b_in_wr, b_in_rdy, b_key_wr, b_key_rdy, b_out_wr, b_out_rdy;
  logic [15:0] b_key_in;
  logic [3:0]  b_dec_cnt;

  decrypt_pipe_param #(.W(16), .NUM_STAGES(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .key_in(key_in), .key_wr(key_wr), .key_rdy(key_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .dec_cnt(dec_cnt)
  );

  decrypt_pipe_param #(.W(16), .NUM_STAGES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_ctrl(b_in_ctrl), .in_wr(b_in_wr),
    .in_rdy(b_in_rdy), .key_in(b_key_in), .key_wr(b_key_wr), .key_rdy(b_key_rdy),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .out_wr(b_out_wr), .out_rdy(b_out_rdy),
    .dec_cnt(b_dec_cnt)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: apply the round rule word by word, n times, unless it is a header.
  function automatic logic [63:0] mdl(input logic [63:0] d, input logic [7:0] c,
                                      input logic [79:0] keys, input int n);
    logic [15:0] w0, w1, w2, w3, k, r, n0, n1, n2, n3;
    if (c != 8'h00) return d;
    {w3, w2, w1, w0} = d;
    for (int s = 0; s < n; s++) begin
      k  = keys[16*s +: 16];
      r  = 16'((k << 1) | (k >> 15));
      n0 = w1 + k;
      n1 = w0 ^ k;
      n2 = w3 ^ r;
      n3 = w2 - k;
      {w0, w1, w2, w3} = {n0, n1, n2, n3};
    end
    return {w3, w2, w1, w0};
  endfunction

  task automatic load_key(input logic [79:0] k);
    @(negedge clk);
    in_wr  = 1'b0;
    key_in = k;
    key_wr = 1'b1;
    #1 chk("key_rdy when idle", key_rdy, 1);
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    in_data = d;
    in_ctrl = c;
    in_wr   = 1'b1;
    #1 chk("in_rdy on push", in_rdy, 1);
    @(posedge clk);
    #1 in_wr = 1'b0;
  endtask

  // Returns at the negedge where out_wr is first seen; lat counts edges since accept.
  task automatic pop(output logic [63:0] d, output logic [7:0] c, output int lat);
    out_rdy = 1'b1;
    lat = 1;
    @(negedge clk);
    while (!out_wr && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("out_wr arrives", out_wr, 1);
    d = out_data;
    c = out_ctrl;
  endtask

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic [15:0] k;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[5];

  logic [79:0] cur_keys, new_keys;
  logic [63:0] d, hold_data, beats[20];
  logic [7:0]  c, ctrls[20];
  logic [63:0] exp_q[$];
  logic [7:0]  expc_q[$];
  int lat, sent, got, cyc, exp_cnt;
  bit hold_pending, saw_full, seen;

  initial begin
    tbl[0] = '{64'h0, 8'h00, 16'h0001, 64'hFFFF_0002_0001_0001};
    tbl[1] = '{64'h0004_0003_0002_0001, 8'h00, 16'h0000, 64'h0003_0004_0001_0002};
    tbl[2] = '{64'hDEAD_BEEF_0123_4567, 8'hFF, 16'h1234, 64'hDEAD_BEEF_0123_4567};
    tbl[3] = '{64'h0, 8'h00, 16'h8000, 64'h8000_0001_8000_8000};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 16'h0001, 64'hFFFE_FFFD_FFFE_0000};

    in_data = '0; in_ctrl = '0; in_wr = 0; key_in = '0; key_wr = 0; out_rdy = 1;
    b_in_data = '0; b_in_ctrl = '0; b_in_wr = 0; b_key_in = '0; b_key_wr = 0; b_out_rdy = 1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset out_wr", out_wr, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_ctrl", out_ctrl, 0);
    chk("reset dec_cnt", dec_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("in_rdy after reset", in_rdy, 1);
    chk("key_rdy after reset", key_rdy, 1);

    // Single beat, zero keys: latency 5, one-cycle out_wr, count 1
    push(64'h0004_0003_0002_0001, 8'h00);
    pop(d, c, lat);
    chk("zero-key latency", 64'(lat), 5);
    chk("zero-key data", d, 64'h0003_0004_0001_0002);
    chk("zero-key ctrl", c, 0);
    @(negedge clk);
    chk("out_wr one cycle", out_wr, 0);
    chk("dec_cnt after first", dec_cnt, 1);
    exp_cnt = 1;

    // Header bypass under nonzero keys, then a data beat through the same keys
    cur_keys = {$urandom, $urandom, 16'($urandom)};
    load_key(cur_keys);
    push(64'hDEAD_BEEF_0123_4567, 8'hFF);
    pop(d, c, lat);
    chk("header latency", 64'(lat), 5);
    chk("header data", d, 64'hDEAD_BEEF_0123_4567);
    chk("header ctrl", c, 8'hFF);
    @(negedge clk);
    chk("dec_cnt after header", dec_cnt, 1);
    d = {$urandom, $urandom};
    push(d, 8'h00);
    pop(hold_data, c, lat);
    chk("keyed beat data", hold_data, mdl(d, 8'h00, cur_keys, 5));
    @(negedge clk);
    exp_cnt = 2;
    chk("dec_cnt after keyed", dec_cnt, 64'(exp_cnt));

    // Single-stage vector table
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_key_in = tbl[i].k;
      b_key_wr = 1'b1;
      #1 chk("b key_rdy", b_key_rdy, 1);
      @(negedge clk);
      b_key_wr  = 1'b0;
      b_in_data = tbl[i].d;
      b_in_ctrl = tbl[i].c;
      b_in_wr   = 1'b1;
      @(negedge clk);
      b_in_wr = 1'b0;
      chk($sformatf("vec%0d out_wr", i), b_out_wr, 1);
      chk($sformatf("vec%0d data", i), b_out_data, tbl[i].exp);
      chk($sformatf("vec%0d ctrl", i), b_out_ctrl, tbl[i].c);
    end
    @(negedge clk);
    chk("b dec_cnt after table", b_dec_cnt, 4);

    // Saturation: 15 more data beats at full rate; 4+15 must clamp at 15
    for (int i = 0; i < 15; i++) begin
      b_in_data = {$urandom, $urandom};
      b_in_ctrl = 8'h00;
      b_in_wr   = 1'b1;
      @(negedge clk);
    end
    b_in_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("b dec_cnt saturated", b_dec_cnt, 4'hF);

    // Random stream with out_rdy toggling every 3 cycles
    cur_keys = {$urandom, $urandom, 16'($urandom)};
    load_key(cur_keys);
    for (int i = 0; i < 20; i++) begin
      beats[i] = {$urandom, $urandom};
      ctrls[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    end
    sent = 0; got = 0; cyc = 0; hold_pending = 0; saw_full = 0;
    while ((sent < 20 || got < 20) && cyc < 600) begin
      @(negedge clk);
      out_rdy = ((cyc / 3) % 2) == 1;
      in_wr   = sent < 20;
      in_data = beats[sent % 20];
      in_ctrl = ctrls[sent % 20];
      #1;
      if (hold_pending) begin
        chk("stall holds out_wr", out_wr, 1);
        chk("stall holds data", out_data, hold_data);
      end
      if (!in_rdy) saw_full = 1;
      if (out_wr && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected output", 1, 0);
        end else begin
          chk($sformatf("stream beat %0d data", got), out_data, exp_q.pop_front());
          chk($sformatf("stream beat %0d ctrl", got), out_ctrl, expc_q.pop_front());
        end
        if (out_ctrl == 8'h00) exp_cnt++;
        got++;
      end
      hold_pending = out_wr && !out_rdy;
      hold_data    = out_data;
      if (in_wr && in_rdy) begin
        exp_q.push_back(mdl(in_data, in_ctrl, cur_keys, 5));
        expc_q.push_back(in_ctrl);
        sent++;
      end
      cyc++;
    end
    in_wr = 1'b0;
    out_rdy = 1'b1;
    chk("stream beats out", 64'(got), 20);
    chk("stream beats in", 64'(sent), 20);
    chk("in_rdy dropped when full", 64'(saw_full), 1);
    @(negedge clk);
    chk("stream nothing extra", out_wr, 0);
    chk("dec_cnt after stream", dec_cnt, 64'(exp_cnt));

    // Key write while busy is dropped; reissued when idle it takes effect
    new_keys = {$urandom, $urandom, 16'($urandom)};
    d = {$urandom, $urandom};
    push(d, 8'h00);
    @(negedge clk);
    key_in = new_keys;
    key_wr = 1'b1;
    #1 chk("key_rdy while busy", key_rdy, 0);
    @(negedge clk);
    key_wr = 1'b0;
    pop(hold_data, c, lat);
    chk("in-flight uses old key", hold_data, mdl(d, 8'h00, cur_keys, 5));
    load_key(new_keys);
    d = {$urandom, $urandom};
    push(d, 8'h00);
    pop(hold_data, c, lat);
    chk("next beat uses new key", hold_data, mdl(d, 8'h00, new_keys, 5));
    @(negedge clk);

    // Reset with beats in flight
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      in_ctrl = 8'h00;
      in_wr   = 1'b1;
      @(negedge clk);
    end
    in_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("beat at output before reset", out_wr, 1);
    rst_n = 1'b0;
    #1;
    chk("reset flush out_wr", out_wr, 0);
    chk("reset flush out_data", out_data, 0);
    chk("reset flush dec_cnt", dec_cnt, 0);
    chk("reset flush b dec_cnt", b_dec_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_wr) seen = 1;
    end
    chk("no stale beat after reset", 64'(seen), 0);
    d = {$urandom, $urandom};
    push(d, 8'h00);
    pop(hold_data, c, lat);
    chk("key bank cleared by reset", hold_data, mdl(d, 8'h00, 80'h0, 5));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
    $fatal(1);
  end

endmodule
